// File: rtl/tl_master_bridge.sv
// -----------------------------------------------------------------------------
// tl_master_bridge
//
// Purpose:
//   Accepts load/store requests from the processor core, buffers them in a
//   small FIFO and issues them one at a time as a 55-bit A-channel word with an
//   a_valid strobe. After a fixed response window the 47-bit D-channel is
//   sampled and the read data / error status is returned to the core. Only one
//   transaction is outstanding, so responses come back in request order.
//
// Parameters:
//   FIFO_DEPTH  request buffer entries (power of 2, >= 2)
//   RESP_WAIT   cycles a_valid is held high before the D-channel is sampled
//   SOURCE_ID   2-bit value driven on a_source
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   req_valid  in   core request strobe
//   req_ready  out  FIFO not full (0 while reset is low)
//   req_we     in   1 = store (PutFullData), 0 = load (Get)
//   req_addr   in   10-bit word address
//   req_wdata  in   32-bit store data
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  load data (0 for stores and failed transactions)
//   rsp_error  out  transaction failed
//   a_channel  out  opcode[54:52] param[51:49] size[48:46] source[45:44]
//                   address[43:34] data[33:2] valid[1] ready[0]
//   a_valid    out  A-channel strobe; the slave acts on its rising edge
//   d_channel  in   opcode[46:44] param[43:42] size[41:37] source[36:35]
//                   error[34] data[33:2] valid[1] ready[0]
//
// Build option:
//   TL_SRC_CHECK_EN  when defined, a D-channel source that differs from
//                    SOURCE_ID is also reported as an error.
// -----------------------------------------------------------------------------
module tl_master_bridge #(
    parameter int         FIFO_DEPTH = 2,
    parameter int         RESP_WAIT  = 4,
    parameter logic [1:0] SOURCE_ID  = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [54:0] a_channel,
    output logic        a_valid,
    input  logic [46:0] d_channel
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int WCNT_W  = $clog2(RESP_WAIT + 1);
    localparam int ENTRY_W = 1 + 10 + 32;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(RESP_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    // ------------------------------------------------------------------
    // Request FIFO: storage array without reset, pointers/count with reset
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] pop_entry;

    assign req_ready = reset && (count_reg != FULL_CNT);
    assign push      = req_valid && req_ready;
    assign pop       = (state_reg == S_IDLE) && (count_reg != '0);
    assign pop_entry = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {req_we, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // A-channel header: captured on the pop so the fields are already
    // settled one cycle (SETUP) before the a_valid rising edge, and stay
    // frozen until the next pop.
    // ------------------------------------------------------------------
    logic        pop_we;
    logic [9:0]  pop_addr;
    logic [31:0] pop_wdata;
    logic [52:0] hdr_reg;
    logic        we_reg;

    assign pop_we    = pop_entry[42];
    assign pop_addr  = pop_entry[41:32];
    assign pop_wdata = pop_entry[31:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_reg <= '0;
            we_reg  <= 1'b0;
        end else if (pop) begin
            we_reg  <= pop_we;
            hdr_reg <= {(pop_we ? 3'd0 : 3'd4),    // PutFullData / Get
                        3'd0,                      // param
                        3'd2,                      // size: 4 bytes
                        SOURCE_ID,
                        pop_addr,
                        (pop_we ? pop_wdata : 32'd0)};
        end
    end

    assign a_valid   = (state_reg == S_WAIT);
    // ready bit follows reset directly so it is 0 exactly while reset is low
    assign a_channel = {hdr_reg, a_valid, reset};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [WCNT_W-1:0] wait_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_SETUP) begin
                wait_cnt_reg <= WCNT_W'(1);
            end else if (state_reg == S_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + WCNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (pop) state_next = S_SETUP;
            S_SETUP: state_next = S_WAIT;
            S_WAIT:  if (wait_cnt_reg == WAIT_LAST) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Response check. The slave keeps its D-channel valid bit sticky, so
    // the channel is only looked at in DONE, never edge-detected.
    // ------------------------------------------------------------------
    logic [2:0]  d_opcode;
    logic [1:0]  d_source;
    logic        d_error;
    logic [31:0] d_data;
    logic        d_valid;
    logic [2:0]  exp_opcode;
    logic        rsp_err_calc;
    logic        unused_d;

    assign d_opcode   = d_channel[46:44];
    assign d_source   = d_channel[36:35];
    assign d_error    = d_channel[34];
    assign d_data     = d_channel[33:2];
    assign d_valid    = d_channel[1];
    // AccessAck (0) for stores, AccessAckData (1) for loads
    assign exp_opcode = we_reg ? 3'd0 : 3'd1;

`ifdef TL_SRC_CHECK_EN
    assign rsp_err_calc = !d_valid || d_error || (d_opcode != exp_opcode) ||
                          (d_source != SOURCE_ID);
    assign unused_d     = ^{d_channel[43:37], d_channel[0]};
`else
    assign rsp_err_calc = !d_valid || d_error || (d_opcode != exp_opcode);
    assign unused_d     = ^{d_channel[43:37], d_channel[0], d_source};
`endif

    logic        rsp_valid_reg;
    logic [31:0] rsp_rdata_reg;
    logic        rsp_error_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_error_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= (state_reg == S_DONE);
            if (state_reg == S_DONE) begin
                rsp_error_reg <= rsp_err_calc;
                rsp_rdata_reg <= (!rsp_err_calc && !we_reg) ? d_data : 32'd0;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_error = rsp_error_reg;

endmodule

// File: tb/tb_tl_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_tl_master_bridge
//
// Directed testbench for tl_master_bridge (FIFO_DEPTH=2, RESP_WAIT=4,
// SOURCE_ID=1). A behavioural memory slave answers on each a_valid rising
// edge; its response can be corrupted per transaction through slave_mode.
// A monitor collects responses and checks A-channel strobe spacing and
// field stability.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tl_master_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [54:0] a_channel;
    logic        a_valid;
    logic [46:0] d_channel;

    always #5 clk = ~clk;

    tl_master_bridge #(
        .FIFO_DEPTH (2),
        .RESP_WAIT  (4),
        .SOURCE_ID  (2'd1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .a_channel (a_channel),
        .a_valid   (a_valid),
        .d_channel (d_channel)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    // 0 normal, 1 d_error, 2 bad opcode, 3 d_valid=0, 4 wrong source
    int          slave_mode = 0;
    logic [31:0] mem [1024];

    initial begin
        logic        av_prev;
        logic [2:0]  op;
        logic [2:0]  d_op;
        logic [1:0]  src;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        d_err;
        logic        d_vld;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        d_channel = '0;
        av_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (a_valid && !av_prev) begin
                op    = a_channel[54:52];
                src   = a_channel[45:44];
                addr  = a_channel[43:34];
                d_err = 1'b0;
                d_vld = 1'b1;
                if (op == 3'd0) begin
                    mem[addr] = a_channel[33:2];
                    d_op = 3'd0;
                    data = 32'd0;
                end else begin
                    d_op = 3'd1;
                    data = mem[addr];
                end
                case (slave_mode)
                    1: d_err = 1'b1;
                    2: d_op  = 3'd2;
                    3: d_vld = 1'b0;
                    4: src   = 2'd0;
                    default: ;
                endcase
                d_channel = {d_op, 2'd0, 5'd2, src, d_err, data, d_vld, 1'b1};
            end
            av_prev = a_valid;
        end
    end

    // ---------------- response / strobe monitor ----------------
    int          rsp_cyc_q [$];
    logic [31:0] rsp_data_q [$];
    logic        rsp_err_q [$];
    int          rises   = 0;
    int          low_cnt = 100;
    logic [54:0] ac_cap  = '0;

    initial begin
        logic av_prev_mon;
        av_prev_mon = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_cyc_q.push_back(cyc);
                rsp_data_q.push_back(rsp_rdata);
                rsp_err_q.push_back(rsp_error);
            end
            if (a_valid) begin
                if (!av_prev_mon) begin
                    rises++;
                    check("strobe_low_gap_ge2", 64'(low_cnt >= 2), 64'd1);
                    ac_cap = a_channel;
                end else begin
                    check("a_channel_stable", 64'(a_channel), 64'(ac_cap));
                end
                low_cnt = 0;
            end else begin
                low_cnt++;
            end
            av_prev_mon = a_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic we, input logic [9:0] addr, input logic [31:0] data,
                        output int acc);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        acc       = -1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (acc < 0) check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 300; i++) begin
            if (rsp_cyc_q.size() >= n) break;
            @(negedge clk);
        end
        if (rsp_cyc_q.size() < n) check("rsp_timeout", 64'(rsp_cyc_q.size()), 64'(n));
    endtask

    task automatic get_rsp(output int c, output logic [31:0] d, output logic e);
        if (rsp_cyc_q.size() > 0) begin
            c = rsp_cyc_q.pop_front();
            d = rsp_data_q.pop_front();
            e = rsp_err_q.pop_front();
        end else begin
            c = -1000;
            d = 32'hDEAD_BEEF;
            e = 1'bx;
        end
    endtask

    // one load/store, checks latency 7, data and error
    task automatic single(input string tag, input logic we, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_d,
                          input logic exp_e);
        int          acc;
        int          c;
        logic [31:0] d;
        logic        e;
        push(we, addr, wdata, acc);
        wait_rsp(1);
        get_rsp(c, d, e);
        check({tag, "_latency"}, 64'(c - acc), 64'd7);
        check({tag, "_rdata"}, 64'(d), 64'(exp_d));
        check({tag, "_error"}, 64'(e), 64'(exp_e));
        $display("txn %s: we=%0d addr=%0d rdata=%0h err=%0d lat=%0d", tag, we, addr, d, e, c - acc);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          acc [3];
        int          c [4];
        logic [31:0] d [4];
        logic        e [4];
        logic [54:0] exp_ac;
        int          r0;
        logic        exp_src_err;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_a_valid",   64'(a_valid),   64'd0);
        check("rst_a_channel", 64'(a_channel), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_error", 64'(rsp_error), 64'd0);
        reset = 1'b1;
        #1;
        check("post_rst_a_channel", 64'(a_channel), 64'd1);
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        // store then load
        single("store5", 1'b1, 10'd5, 32'd20, 32'd0, 1'b0);
        exp_ac = {3'd0, 3'd0, 3'd2, 2'd1, 10'd5, 32'd20, 1'b1, 1'b1};
        check("store_a_channel", 64'(ac_cap), 64'(exp_ac));
        single("load5", 1'b0, 10'd5, 32'd0, 32'd20, 1'b0);
        exp_ac = {3'd4, 3'd0, 3'd2, 2'd1, 10'd5, 32'd0, 1'b1, 1'b1};
        check("load_a_channel", 64'(ac_cap), 64'(exp_ac));

        // FIFO full: three requests in consecutive cycles
        push(1'b0, 10'd10, 32'd0, acc[0]);
        push(1'b0, 10'd11, 32'd0, acc[1]);
        push(1'b0, 10'd12, 32'd0, acc[2]);
        check("fifo_full_ready_low", 64'(req_ready), 64'd0);
        wait_rsp(3);
        for (int i = 0; i < 3; i++) get_rsp(c[i], d[i], e[i]);
        check("fifo_rsp0_latency", 64'(c[0] - acc[0]), 64'd7);
        check("fifo_rsp0_rdata", 64'(d[0]), 64'h0000_0000_A000_000A);
        check("fifo_rsp1_rdata", 64'(d[1]), 64'h0000_0000_A000_000B);
        check("fifo_rsp2_rdata", 64'(d[2]), 64'h0000_0000_A000_000C);
        check("fifo_rsp1_spacing", 64'(c[1] - c[0]), 64'd7);
        check("fifo_rsp2_spacing", 64'(c[2] - c[1]), 64'd7);
        check("fifo_ready_back", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++)
            $display("txn fifo%0d: rdata=%0h err=%0d cyc=%0d", i, d[i], e[i], c[i]);

        // error paths
        slave_mode = 1;
        single("err_derror", 1'b0, 10'd5, 32'd0, 32'd0, 1'b1);
        slave_mode = 2;
        single("err_opcode", 1'b0, 10'd5, 32'd0, 32'd0, 1'b1);
        slave_mode = 3;
        single("err_dvalid", 1'b0, 10'd5, 32'd0, 32'd0, 1'b1);
        slave_mode = 1;
        single("err_store", 1'b1, 10'd7, 32'd99, 32'd0, 1'b1);
        slave_mode = 0;
        single("load_after_err", 1'b0, 10'd5, 32'd0, 32'd20, 1'b0);

        // source check option
        slave_mode = 4;
`ifdef TL_SRC_CHECK_EN
        exp_src_err = 1'b1;
`else
        exp_src_err = 1'b0;
`endif
        single("src_mismatch", 1'b0, 10'd5, 32'd0, (exp_src_err ? 32'd0 : 32'd20), exp_src_err);
        slave_mode = 0;

        // strobe spacing: four back-to-back loads
        r0 = rises;
        for (int i = 0; i < 4; i++) push(1'b0, 10'(20 + i), 32'd0, acc[0]);
        wait_rsp(4);
        for (int i = 0; i < 4; i++) get_rsp(c[i], d[i], e[i]);
        check("strobe_rise_count", 64'(rises - r0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("b2b_rdata", 64'(d[i]), 64'(32'hA000_0000 | (20 + i)));
            $display("txn b2b%0d: rdata=%0h err=%0d cyc=%0d", i, d[i], e[i], c[i]);
        end
        check("b2b_spacing", 64'(c[3] - c[2]), 64'd7);

        // reset in the 2nd WAIT cycle
        push(1'b0, 10'd5, 32'd0, acc[0]);
        for (int i = 0; i < 50; i++) begin
            if (a_valid) break;
            @(negedge clk);
        end
        check("rstwait_saw_strobe", 64'(a_valid), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rstwait_a_valid", 64'(a_valid), 64'd0);
        check("rstwait_req_ready", 64'(req_ready), 64'd0);
        check("rstwait_a_channel", 64'(a_channel), 64'd0);
        check("rstwait_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("rstwait_no_rsp", 64'(rsp_cyc_q.size()), 64'd0);
        $display("txn rst_mid_wait: abandoned, responses seen=%0d", rsp_cyc_q.size());
        single("load_after_rst", 1'b0, 10'd5, 32'd0, 32'd20, 1'b0);

        repeat (10) @(negedge clk);
        check("no_extra_rsp", 64'(rsp_cyc_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
